// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//   Multi-song note sequencer for the synth voice path. It stores NUM_SONGS
//   note patterns of DEPTH steps each, plus a last-step register per song.
//   The selected song plays one step per step_tick. Playback supports a
//   start/stop toggle, pause, one-shot or loop mode, and an end-of-song pulse.
//
// Ports
//   clk, rst    : system clock; synchronous active-high reset
//   toggle      : one-cycle start/stop pulse
//   pause       : level; high freezes playback
//   loop_en     : level; sampled when the last step is consumed
//   song_sel    : song to play, latched on start
//   step_tick   : one-cycle step strobe from the clock divider
//   wr_en, wr_song, wr_addr, wr_note : pattern memory write port
//   len_wr, len_val                  : last-step register write for wr_song
//   note_out    : registered note code; rest (all ones) when idle
//   playing     : high in PLAY or PAUSE
//   step_idx    : current step index
//   song_done   : one-cycle pulse when the last step is consumed
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int NOTE_W    = 4,
    parameter int DEPTH     = 256,
    parameter int NUM_SONGS = 4,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int SONG_W    = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              toggle,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              step_tick,
    input  logic              wr_en,
    input  logic [SONG_W-1:0] wr_song,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              len_wr,
    input  logic [ADDR_W-1:0] len_val,
    output logic [NOTE_W-1:0] note_out,
    output logic              playing,
    output logic [ADDR_W-1:0] step_idx,
    output logic              song_done
);

    localparam logic [NOTE_W-1:0] REST = {NOTE_W{1'b1}};
    localparam int                MEM_W = SONG_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   step_reg, step_next;
    logic [SONG_W-1:0]   song_reg, song_next;
    logic                done_reg, done_next;
    logic [NOTE_W-1:0]   note_reg;
    logic [ADDR_W-1:0]   last_reg [NUM_SONGS];
    logic [ADDR_W-1:0]   last_cur;

    // Pattern memory, addressed {song, step}; no reset so it maps to block RAM.
    logic [NOTE_W-1:0]   mem [NUM_SONGS*DEPTH];
    logic [MEM_W-1:0]    rd_addr;
    logic [MEM_W-1:0]    wr_mem_addr;

    assign rd_addr     = {song_reg, step_reg};
    assign wr_mem_addr = {wr_song, wr_addr};
    assign last_cur    = last_reg[song_reg];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        song_next  = song_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (toggle) begin
                    state_next = PLAY;
                    song_next  = song_sel;
                    step_next  = '0;
                end
            end
            PLAY: begin
                // toggle outranks pause, which outranks step_tick
                if (toggle) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (pause) begin
                    state_next = PAUSE;
                end else if (step_tick) begin
                    // >= so a song shortened below the current step still ends
                    if (step_reg >= last_cur) begin
                        done_next = 1'b1;
                        step_next = '0;
                        if (!loop_en) begin
                            state_next = IDLE;
                        end
                    end else begin
                        step_next = step_reg + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (toggle) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (!pause) begin
                    state_next = PLAY;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            song_reg  <= '0;
            done_reg  <= 1'b0;
            note_reg  <= REST;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            song_reg  <= song_next;
            done_reg  <= done_next;
            // Registered memory read: note lags step_idx by one cycle.
            if (state_reg != IDLE) begin
                note_reg <= mem[rd_addr];
            end else begin
                note_reg <= REST;
            end
        end
    end

    // Write port; a same-cycle read of this location sees the old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_mem_addr] <= wr_note;
        end
    end

    // Per-song last-step registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (rst) begin
                last_reg[i] <= ADDR_W'(DEPTH - 1);
            end else if (len_wr && (wr_song == SONG_W'(i))) begin
                last_reg[i] <= len_val;
            end
        end
    end

    assign note_out  = note_reg;
    assign playing   = (state_reg != IDLE);
    assign step_idx  = step_reg;
    assign song_done = done_reg;

endmodule
